// File: rtl/rib_arb.sv
// Round-robin arbiter that lets four RIB masters share one slave port. Each
// transaction is tracked from grant to slave ack, and aborted by a timeout counter.
module rib_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          m_req,
  input  logic [3:0]          m_we,
  input  logic [4*ADDR_W-1:0] m_addr,
  input  logic [4*DATA_W-1:0] m_wdata,
  output logic [3:0]          m_gnt,
  output logic [3:0]          m_ack,
  output logic [3:0]          m_err,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                s_req,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ack,
  output logic                rib_hold_flag
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [1:0] owner_q;
  logic [1:0] ptr_q;
  logic [7:0] tcnt_q;
  logic [3:0] gnt_q;

  logic [ADDR_W-1:0] addr_arr [4];
  logic [DATA_W-1:0] wdata_arr[4];
  logic [3:0]        rot_req;
  logic [1:0]        win_off;
  logic [1:0]        win_idx;
  logic              busy;
  logic              own_req;
  logic              ack_hit;
  logic              tmo_hit;
  logic [3:0]        owner_oh;

  // Unpack the per-master buses and rotate requests so index 0 is the
  // current highest-priority master.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mst
      assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
      assign rot_req[gi]   = m_req[ptr_q + 2'(gi)];
    end
  endgenerate

  always_comb begin
    win_off = 2'd3;
    if (rot_req[0])      win_off = 2'd0;
    else if (rot_req[1]) win_off = 2'd1;
    else if (rot_req[2]) win_off = 2'd2;
  end

  assign win_idx  = ptr_q + win_off;
  assign busy     = (state_q == BUSY);
  assign own_req  = m_req[owner_q];
  assign owner_oh = 4'b0001 << owner_q;

  assign s_req   = busy & own_req;
  assign s_we    = busy & m_we[owner_q];
  assign s_addr  = busy ? addr_arr[owner_q]  : '0;
  assign s_wdata = busy ? wdata_arr[owner_q] : '0;

  // Ack has priority over a timeout landing in the same cycle.
  assign ack_hit = s_req & s_ack;
  assign tmo_hit = s_req & ~s_ack & (tcnt_q == TCNT_LAST);

  assign m_ack   = ack_hit ? owner_oh : 4'b0000;
  assign m_err   = tmo_hit ? owner_oh : 4'b0000;
  assign m_rdata = ack_hit ? s_rdata : '0;
  assign m_gnt   = gnt_q;

  assign rib_hold_flag = rst & m_req[0] & ~m_ack[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      tcnt_q  <= 8'd0;
      gnt_q   <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (|m_req) begin
            owner_q <= win_idx;
            gnt_q   <= 4'b0001 << win_idx;
            tcnt_q  <= 8'd0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (ack_hit | tmo_hit | ~own_req) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            ptr_q   <= owner_q + 2'd1;
          end else if (tcnt_q != 8'hFF) begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/rib_arb.md
# rib_arb

Round-robin arbiter for the shared RIB system bus. It lets four bus masters share one slave port: master 0 is the core load/store path, and masters 1–3 are the debug/JTAG and DMA-style agents. Each transaction is tracked from grant to slave acknowledge, and a transaction whose slave never responds is aborted by a timeout counter. The block also produces `rib_hold_flag` for the pipeline controller, so the core PC is held while the core's bus access is pending.

## Interface
- `ADDR_W`, default 32: address width per master.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 255: maximum number of BUSY cycles without `s_ack` before abort. Legal range is 2..255.

Ports:
- `clk` in, 1 bit: single clock.
- `rst` in, 1 bit: reset, asynchronous, active-low.
- `m_req` in, 4 bits: per-master request. Must stay high and stable until `m_ack` or `m_err` for that master.
- `m_we` in, 4 bits: per-master write enable.
- `m_addr` in, 4×`ADDR_W` bits: packed addresses; master i occupies bits [i*ADDR_W +: ADDR_W].
- `m_wdata` in, 4×`DATA_W` bits: packed write data, same packing as `m_addr`.
- `m_gnt` out, 4 bits: one-hot, registered; marks the current bus owner.
- `m_ack` out, 4 bits: one-cycle completion pulse to the owner.
- `m_err` out, 4 bits: one-cycle timeout-abort pulse to the owner.
- `m_rdata` out, `DATA_W` bits: shared read data; valid only in a cycle where `m_ack` is high.
- `s_req` out, 1 bit: slave request.
- `s_we` out, 1 bit: slave write enable.
- `s_addr` out, `ADDR_W` bits: slave address.
- `s_wdata` out, `DATA_W` bits: slave write data.
- `s_rdata` in, `DATA_W` bits: slave read data.
- `s_ack` in, 1 bit: slave completion. Sampled only while `s_req` is high.
- `rib_hold_flag` out, 1 bit: goes to the pipeline controller; high means hold the PC.

## Operation
- States: IDLE and BUSY.
- Registers:
  - `state`
  - `owner[1:0]`
  - `ptr[1:0]`: the highest-priority index for the next grant.
  - `tcnt[7:0]`
  - `m_gnt`
- Reset (`rst` low, asynchronous) sets `state`=IDLE, `owner`=0, `ptr`=0, `tcnt`=0, `m_gnt`=0.
- Winner selection in IDLE: search order is `ptr`, `ptr`+1, `ptr`+2, `ptr`+3, all mod 4. The first index with `m_req` high wins.
- IDLE with any request: on the next edge, `owner`=winner, `m_gnt`=onehot(winner), `tcnt`=0, `state`=BUSY.
- IDLE with no request: stay in IDLE; `ptr` is unchanged.
- Outputs in BUSY:
  - `s_req` = `m_req[owner]`.
  - `s_we`, `s_addr`, `s_wdata` = the owner's fields, muxed combinationally from live master inputs.
- Outputs in IDLE: `s_req`, `s_we`, `s_addr`, `s_wdata` are all 0.
- Completion, BUSY with `s_req` and `s_ack` both high:
  - `m_ack[owner]`=1 combinationally in the same cycle.
  - `m_rdata`=`s_rdata` in that cycle.
  - Next edge: `state`=IDLE, `m_gnt`=0, `ptr`=`owner`+1 (mod 4).
- Abandon, BUSY with `m_req[owner]` low:
  - `s_ack` is ignored.
  - Next edge: IDLE, `m_gnt`=0, `ptr`=`owner`+1.
  - No `m_ack` and no `m_err` is issued.
- Timeout, BUSY with `s_req` high, `s_ack` low and `tcnt`==`TIMEOUT`-1:
  - `m_err[owner]`=1 in that cycle.
  - `s_req` stays high in that cycle.
  - Next edge: IDLE, `m_gnt`=0, `ptr`=`owner`+1.
- Otherwise in BUSY, `tcnt` increments; it saturates at 255.
- `m_rdata` is 0 whenever no `m_ack` bit is high.
- `rib_hold_flag` = `m_req[0]` & ~`m_ack[0]`, combinational. It is 0 while `rst` is low.

## Timing
- Minimum transaction:
  - Request at edge N, sampled in IDLE.
  - `m_gnt`/`s_req` high in cycle N+1; slave may ack in that same cycle.
  - Back in IDLE in cycle N+2.
- Throughput:
  - At most one transaction per 2 cycles, because every transaction returns through IDLE.
  - A master loses at most 3 other transactions before it is granted.
- Ack and timeout in the same cycle: ack wins; `m_err` stays low.
- Reset asserted mid-BUSY:
  - Immediately: `m_gnt`=0, `s_req`=0, no ack or err pulse.
  - The slave is responsible for discarding any partial access.
- `m_ack`, `m_err` and `rib_hold_flag` have zero latency from `s_ack`/`m_req` (combinational paths). The slave must not combinationally derive `s_ack` from `m_ack`.

## Test plan
- Single read:
  - Stimulus: `m_req`=4'b0001, `m_addr[0]`=0x1000_0004; slave acks 1 cycle after `s_req` with `s_rdata`=0xDEADBEEF.
  - Required: `m_gnt`=0001 one cycle after the request; `m_ack[0]` pulse with `m_rdata`=0xDEADBEEF.
  - Required: `rib_hold_flag` high from the request until the ack cycle, low after.
- Round-robin:
  - Stimulus: `m_req`=4'b1111 held, each master re-requesting immediately after its ack; slave acks immediately.
  - Required grant order: 0,1,2,3,0; a new grant every 2 cycles.
- Priority rotation:
  - Stimulus: after master 2 completes, `m_req`=4'b0101.
  - Required: master 0 is granted (`ptr`=3, search 3→0), not master 2.
- Timeout:
  - Stimulus: `TIMEOUT`=4; master 1 requests; slave never acks.
  - Required: `m_err[1]` pulses in the 4th BUSY cycle; next cycle IDLE with `m_gnt`=0; no `m_ack`.
- Abandon and ack/timeout collision:
  - Abandon stimulus: master 3 drops `m_req` in its 2nd BUSY cycle. Required: `s_req` low that cycle, no ack/err, IDLE next cycle.
  - Collision stimulus: `s_ack` high exactly at `tcnt`=`TIMEOUT`-1. Required: `m_ack` pulses, `m_err` stays 0.
- Reset mid-transaction:
  - Stimulus: pull `rst` low asynchronously in cycle 2 of BUSY.
  - Required: `m_gnt`=0, `s_req`=0, `rib_hold_flag`=0 without a clock edge.
  - Required: after release, the next grant follows `ptr`=0.
